// File: rtl/signal_ramper.sv
// signal_ramper: linear amplitude envelope (ramp-up / hold / ramp-down) over a 16-bit sample stream.
// Three-stage pipeline; the optional output clamp is enabled by defining SIGNAL_RAMPER_LIMIT_EN.
module signal_ramper #(
  parameter int ENV_W = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] signal_in,
  input  logic               signal_valid_in,
  input  logic               ramp_start,
  input  logic               ramp_stop,
  input  logic [15:0]        ramp_inc,
  input  logic signed [15:0] limit_upper,
  input  logic signed [15:0] limit_lower,
  output logic signed [15:0] signal_out,
  output logic               signal_valid_out,
  output logic [1:0]         ramp_state,
  output logic               ramp_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [ENV_W-1:0] UNITY = ENV_W'(32768);
  localparam int PW = 16 + ENV_W;

  state_t             state;
  logic [ENV_W-1:0]   env;
  logic [ENV_W:0]     up_sum;
  logic               up_sat;
  logic               down_done;

  // A zero increment means "jump immediately" in both directions.
  always_comb begin
    up_sum    = {1'b0, env} + (ENV_W+1)'(ramp_inc);
    up_sat    = (ramp_inc == 16'd0) || (up_sum >= (ENV_W+1)'(UNITY));
    down_done = (ramp_inc == 16'd0) || (env <= ENV_W'(ramp_inc));
  end

  assign ramp_state = state;

  // A start accepted in IDLE already applies the first ramp-up step to that cycle's valid sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      env       <= '0;
      ramp_done <= 1'b0;
    end else begin
      ramp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ramp_start && !ramp_stop) begin
            state <= RAMP_UP;
            if (signal_valid_in) begin
              if (up_sat) begin
                env   <= UNITY;
                state <= HOLD;
              end else begin
                env <= up_sum[ENV_W-1:0];
              end
            end
          end
        end
        RAMP_UP: begin
          if (ramp_stop) begin
            state <= RAMP_DOWN;
          end else if (signal_valid_in) begin
            if (up_sat) begin
              env   <= UNITY;
              state <= HOLD;
            end else begin
              env <= up_sum[ENV_W-1:0];
            end
          end
        end
        HOLD: begin
          env <= UNITY;
          if (ramp_stop) state <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (ramp_start && !ramp_stop) begin
            state <= RAMP_UP;
          end else if (signal_valid_in) begin
            if (down_done) begin
              env       <= '0;
              state     <= IDLE;
              ramp_done <= 1'b1;
            end else begin
              env <= env - ENV_W'(ramp_inc);
            end
          end
        end
      endcase
    end
  end

  logic signed [15:0]   s1_sample;
  logic                 s1_valid;
  logic [ENV_W-1:0]     s1_env;
  logic signed [PW-1:0] s2_product;
  logic                 s2_valid;
  logic signed [PW-1:0] mul_a;
  logic signed [PW-1:0] mul_b;
  logic signed [15:0]   scaled;
  logic signed [15:0]   clamped;
  logic                 unused_product_bits;

  // Both factors are widened to the full product width so the signed multiply is exact.
  always_comb begin
    mul_a = {{ENV_W{s1_sample[15]}}, s1_sample};
    mul_b = {16'b0, s1_env};
  end

  // Selecting bits [ENV_W+13:ENV_W-2] is the arithmetic shift right by 15 (floor).
  always_comb begin
    scaled  = s2_product[ENV_W+13:ENV_W-2];
    clamped = scaled;
`ifdef SIGNAL_RAMPER_LIMIT_EN
    if (clamped > limit_upper) clamped = limit_upper;
    if (clamped < limit_lower) clamped = limit_lower;
`endif
  end

  assign unused_product_bits = ^{s2_product[PW-1:ENV_W+14], s2_product[ENV_W-3:0]};

`ifndef SIGNAL_RAMPER_LIMIT_EN
  logic unused_limits;
  assign unused_limits = ^{limit_upper, limit_lower};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sample        <= '0;
      s1_valid         <= 1'b0;
      s1_env           <= '0;
      s2_product       <= '0;
      s2_valid         <= 1'b0;
      signal_out       <= '0;
      signal_valid_out <= 1'b0;
    end else begin
      s1_sample        <= signal_in;
      s1_valid         <= signal_valid_in;
      s1_env           <= env;
      s2_product       <= mul_a * mul_b;
      s2_valid         <= s1_valid;
      signal_out       <= clamped;
      signal_valid_out <= s2_valid;
    end
  end

endmodule

// File: tb/tb_signal_ramper.sv
// Self-checking bench for signal_ramper: hand-derived vector table, corner-case sequences,
// and randomized traffic compared against an arithmetic reference model.
module tb_signal_ramper;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] signal_in;
  logic               signal_valid_in;
  logic               ramp_start;
  logic               ramp_stop;
  logic [15:0]        ramp_inc;
  logic signed [15:0] limit_upper;
  logic signed [15:0] limit_lower;
  logic signed [15:0] signal_out;
  logic               signal_valid_out;
  logic [1:0]         ramp_state;
  logic               ramp_done;

  always #5 clk = ~clk;

  signal_ramper dut (
    .clk              (clk),
    .reset            (reset),
    .signal_in        (signal_in),
    .signal_valid_in  (signal_valid_in),
    .ramp_start       (ramp_start),
    .ramp_stop        (ramp_stop),
    .ramp_inc         (ramp_inc),
    .limit_upper      (limit_upper),
    .limit_lower      (limit_lower),
    .signal_out       (signal_out),
    .signal_valid_out (signal_valid_out),
    .ramp_state       (ramp_state),
    .ramp_done        (ramp_done)
  );

  typedef struct { bit valid; int value; } pipe_rec_t;
  typedef struct { bit start; bit stop; int st; bit done; bit vout; int out; } vec_t;

  int        checks = 0;
  int        failures = 0;
  string     phase = "init";
  pipe_rec_t pipeQ[$];
  int        mState, mEnv, expOut;
  bit        mDone, expValid;
  int        seen[$];

  function automatic void checkValue(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s/%s: got %0d, expected %0d", phase, name, actual, expected);
    end
  endfunction

  function automatic int clampModel(int v);
    int r;
    r = v;
`ifdef SIGNAL_RAMPER_LIMIT_EN
    if (r > int'(limit_upper)) r = int'(limit_upper);
    if (r < int'(limit_lower)) r = int'(limit_lower);
`endif
    return r;
  endfunction

  // Outputs emerge after the third clock edge, so two empty slots precede the first sample.
  function automatic void modelReset();
    pipe_rec_t z;
    z.valid = 1'b0;
    z.value = 0;
    mState = 0;
    mEnv = 0;
    mDone = 1'b0;
    expValid = 1'b0;
    expOut = 0;
    pipeQ.delete();
    for (int i = 0; i < 2; i++) pipeQ.push_back(z);
  endfunction

  function automatic void rampUpStep(int inc);
    if (inc == 0 || mEnv + inc >= 32768) begin
      mEnv = 32768;
      mState = 2;
    end else begin
      mEnv = mEnv + inc;
      mState = 1;
    end
  endfunction

  function automatic void modelStep(bit start, bit stop, bit valid, int sample, int inc);
    pipe_rec_t r;
    r.valid = valid;
    r.value = int'((longint'(sample) * longint'(mEnv)) >>> 15);
    pipeQ.push_back(r);
    r = pipeQ.pop_front();
    expValid = r.valid;
    expOut = clampModel(r.value);
    mDone = 1'b0;
    case (mState)
      0: if (start && !stop) begin
           mState = 1;
           if (valid) rampUpStep(inc);
         end
      1: if (stop) mState = 3;
         else if (valid) rampUpStep(inc);
      2: if (stop) mState = 3;
      default: begin
        if (start && !stop) mState = 1;
        else if (valid) begin
          if (inc == 0 || mEnv <= inc) begin
            mEnv = 0;
            mState = 0;
            mDone = 1'b1;
          end else begin
            mEnv = mEnv - inc;
          end
        end
      end
    endcase
  endfunction

  task automatic checkOutput();
    checkValue("valid_out", int'(signal_valid_out), int'(expValid));
    if (expValid) checkValue("signal_out", int'(signal_out), expOut);
    checkValue("ramp_state", int'(ramp_state), mState);
    checkValue("ramp_done", int'(ramp_done), int'(mDone));
  endtask

  task automatic applyStimulus(input bit rst, input bit start, input bit stop, input bit valid,
                               input int sample, input int inc);
    reset           = rst;
    ramp_start      = start;
    ramp_stop       = stop;
    signal_valid_in = valid;
    signal_in       = 16'(sample);
    ramp_inc        = 16'(inc);
    @(posedge clk);
    if (rst) modelReset();
    else modelStep(start, stop, valid, sample, inc);
    #1;
    checkOutput();
    if (signal_valid_out) seen.push_back(int'(signal_out));
  endtask

  function automatic void checkSeen(string name, int expected[$]);
    checkValue({name, "_count"}, seen.size(), expected.size());
    foreach (expected[i])
      if (i < seen.size()) checkValue($sformatf("%s[%0d]", name, i), seen[i], expected[i]);
  endfunction

  task automatic flush(input int inc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, inc);
  endtask

  vec_t tbl[18];
  int   expQ[$];
  bit   rRst, rStart, rStop, rValid;
  int   rInc, rSample;
  logic signed [15:0] rWord;

  initial begin
    reset = 1'b1; ramp_start = 1'b0; ramp_stop = 1'b0; signal_valid_in = 1'b0;
    signal_in = '0; ramp_inc = '0;
    limit_upper = 16'sh7fff; limit_lower = 16'sh8000;
    modelReset();

    phase = "reset";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1234, 8192);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1234, 8192);
    checkValue("rst_state", int'(ramp_state), 0);
    checkValue("rst_out", int'(signal_out), 0);
    checkValue("rst_vout", int'(signal_valid_out), 0);
    checkValue("rst_done", int'(ramp_done), 0);

    // Ramp up to hold and back down with ramp_inc=8192 on a constant 16000 input.
    tbl[0]  = '{1, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 2, 0, 1, 4000};
    tbl[4]  = '{0, 0, 2, 0, 1, 8000};
    tbl[5]  = '{0, 0, 2, 0, 1, 12000};
    tbl[6]  = '{0, 0, 2, 0, 1, 16000};
    tbl[7]  = '{0, 0, 2, 0, 1, 16000};
    tbl[8]  = '{0, 1, 3, 0, 1, 16000};
    tbl[9]  = '{0, 0, 3, 0, 1, 16000};
    tbl[10] = '{0, 0, 3, 0, 1, 16000};
    tbl[11] = '{0, 0, 3, 0, 1, 16000};
    tbl[12] = '{0, 0, 0, 1, 1, 12000};
    tbl[13] = '{0, 0, 0, 0, 1, 8000};
    tbl[14] = '{0, 0, 0, 0, 1, 4000};
    tbl[15] = '{0, 0, 0, 0, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 1, 0};
    phase = "table";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, tbl[i].start, tbl[i].stop, 1'b1, 16000, 8192);
      checkValue($sformatf("row%0d_state", i), int'(ramp_state), tbl[i].st);
      checkValue($sformatf("row%0d_done", i), int'(ramp_done), int'(tbl[i].done));
      checkValue($sformatf("row%0d_vout", i), int'(signal_valid_out), int'(tbl[i].vout));
      if (tbl[i].vout) checkValue($sformatf("row%0d_out", i), int'(signal_out), tbl[i].out);
    end

    phase = "gapped";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    seen.delete();
    for (int c = 0; c < 24; c++)
      applyStimulus(1'b0, c == 0, 1'b0, (c % 3) == 0, 16000, 8192);
    flush(8192);
    expQ = '{0, 4000, 8000, 12000, 16000, 16000, 16000, 16000};
    checkSeen("gap_seq", expQ);

    phase = "edge";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    seen.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16000, 0);
    checkValue("inc0_state", int'(ramp_state), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16000, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, -32768, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16000, 0);
    checkValue("startstop_state", int'(ramp_state), 3);
    flush(0);
    expQ = '{0, 16000, -32768, 16000};
    checkSeen("edge_seq", expQ);

    phase = "limits";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    seen.delete();
    limit_upper = 16'sd10000; limit_lower = -16'sd10000;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16000, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16000, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, -16000, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    limit_upper = 16'sd100; limit_lower = 16'sd500;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16000, 0);
    flush(0);
`ifdef SIGNAL_RAMPER_LIMIT_EN
    expQ = '{0, 10000, -10000, 500};
`else
    expQ = '{0, 16000, -16000, 16000};
`endif
    checkSeen("limit_seq", expQ);
    limit_upper = 16'sh7fff; limit_lower = 16'sh8000;

    phase = "midreset";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16000, 8192);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16000, 8192);
    checkValue("pre_state", int'(ramp_state), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16000, 8192);
    checkValue("state", int'(ramp_state), 0);
    checkValue("out", int'(signal_out), 0);
    checkValue("vout", int'(signal_valid_out), 0);
    checkValue("done", int'(ramp_done), 0);
    seen.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16000, 8192);
    flush(8192);
    expQ = '{0, 0, 0, 0, 0, 0};
    checkSeen("post_seq", expQ);

    phase = "random";
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      rRst   = ($urandom_range(0, 199) == 0);
      rStart = ($urandom_range(0, 7) == 0);
      rStop  = ($urandom_range(0, 11) == 0);
      rValid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0: rInc = 0;
        1: rInc = 1000;
        2: rInc = 4096;
        3: rInc = 8192;
        4: rInc = 30000;
        default: rInc = int'(16'($urandom));
      endcase
      if ($urandom_range(0, 9) == 0) rSample = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
      else begin
        rWord = 16'($urandom);
        rSample = int'(rWord);
      end
      if ($urandom_range(0, 49) == 0) begin
        limit_upper = 16'($urandom);
        limit_lower = 16'($urandom);
      end else if ($urandom_range(0, 99) == 0) begin
        limit_upper = 16'sh7fff;
        limit_lower = 16'sh8000;
      end
      applyStimulus(rRst, rStart, rStop, rValid, rSample, rInc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
